imm_extend_pipe: RTL and testbench

- Parametrised immediate-extension unit for the CPU datapath.
- Widens an IN_W-bit immediate to OUT_W bits in one of four modes:
  - sign extend
  - zero extend
  - upper placement (LUI)
  - sign extend then shift left by 2 (branch offset)
- Results are buffered in a 2-entry skid FIFO behind a valid/ready handshake. This lets it sit between decode and execute in the pipelined core.
- Also counts completed output transfers.

---
 rtl/imm_extend_pipe.sv | 103 ++++++++++
 tb/tb_imm_extend_pipe.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/imm_extend_pipe.sv
// Immediate-extension unit: widens an IN_W-bit immediate in one of four modes
// and buffers results in a 2-entry FIFO behind a valid/ready handshake.
module imm_extend_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [IN_W-1:0]  data_i,
    input  logic [1:0]       mode_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [OUT_W-1:0] data_o,
    output logic [1:0]       mode_o,
    output logic [1:0]       count_o,
    output logic [CNT_W-1:0] xfer_cnt_o
);

    localparam logic [1:0] MODE_SIGN   = 2'b00;
    localparam logic [1:0] MODE_ZERO   = 2'b01;
    localparam logic [1:0] MODE_UPPER  = 2'b10;
    localparam logic [1:0] MODE_BRANCH = 2'b11;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [OUT_W-1:0] sext;
    logic [OUT_W-1:0] ext_data;

    assign sext = {{(OUT_W-IN_W){data_i[IN_W-1]}}, data_i};

    always_comb begin
        ext_data = '0;
        case (mode_i)
            MODE_SIGN:   ext_data = sext;
            MODE_ZERO:   ext_data = {{(OUT_W-IN_W){1'b0}}, data_i};
            MODE_UPPER:  ext_data = {data_i, {(OUT_W-IN_W){1'b0}}};
            MODE_BRANCH: ext_data = {sext[OUT_W-3:0], 2'b00};
            default:     ext_data = '0;
        endcase
    end

    logic [OUT_W-1:0] data_mem [2];
    logic [1:0]       mode_mem [2];
    logic [1:0]       count_reg, count_next;
    logic             wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0] xfer_cnt_reg;
    logic             push, pop;

    assign ready_o = (count_reg != 2'd2);
    assign valid_o = (count_reg != 2'd0);
    assign push    = valid_i && ready_o;
    assign pop     = valid_o && ready_i;

    // Stale entries are masked so nothing leaks out while the FIFO is empty.
    assign data_o     = valid_o ? data_mem[rd_ptr_reg] : '0;
    assign mode_o     = valid_o ? mode_mem[rd_ptr_reg] : 2'b00;
    assign count_o    = count_reg;
    assign xfer_cnt_o = xfer_cnt_reg;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_entry
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    data_mem[gi] <= '0;
                    mode_mem[gi] <= 2'b00;
                end else if (push && (wr_ptr_reg == 1'(gi))) begin
                    data_mem[gi] <= ext_data;
                    mode_mem[gi] <= mode_i;
                end
            end
        end
    endgenerate

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 2'd1;
            2'b01:   count_next = count_reg - 2'd1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_reg    <= 2'd0;
            wr_ptr_reg   <= 1'b0;
            rd_ptr_reg   <= 1'b0;
            xfer_cnt_reg <= '0;
        end else begin
            count_reg <= count_next;
            if (push) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg   <= ~rd_ptr_reg;
                xfer_cnt_reg <= xfer_cnt_reg + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Scoreboard bench for imm_extend_pipe: default instance plus a narrow-counter
// instance and a 12->20 bit instance.
module tb_imm_extend_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    // Default instance
    logic        rst;
    logic        a_valid, a_ready_o, a_valid_o, a_ready_i;
    logic [15:0] a_data;
    logic [1:0]  a_mode, a_mode_o, a_count;
    logic [31:0] a_data_o;
    logic [15:0] a_xfer;

    imm_extend_pipe dut_a (
        .clk_i(clk), .rst_i(rst), .valid_i(a_valid), .ready_o(a_ready_o),
        .data_i(a_data), .mode_i(a_mode), .valid_o(a_valid_o), .ready_i(a_ready_i),
        .data_o(a_data_o), .mode_o(a_mode_o), .count_o(a_count), .xfer_cnt_o(a_xfer)
    );

    // Counter-wrap instance
    logic        b_valid, b_ready_o, b_valid_o, b_ready_i;
    logic [15:0] b_data;
    logic [1:0]  b_mode, b_mode_o, b_count;
    logic [31:0] b_data_o;
    logic [3:0]  b_xfer;

    imm_extend_pipe #(.CNT_W(4)) dut_b (
        .clk_i(clk), .rst_i(rst), .valid_i(b_valid), .ready_o(b_ready_o),
        .data_i(b_data), .mode_i(b_mode), .valid_o(b_valid_o), .ready_i(b_ready_i),
        .data_o(b_data_o), .mode_o(b_mode_o), .count_o(b_count), .xfer_cnt_o(b_xfer)
    );

    // Narrow-width instance
    logic        c_valid, c_ready_o, c_valid_o, c_ready_i;
    logic [11:0] c_data;
    logic [1:0]  c_mode, c_mode_o, c_count;
    logic [19:0] c_data_o;
    logic [15:0] c_xfer;

    imm_extend_pipe #(.IN_W(12), .OUT_W(20)) dut_c (
        .clk_i(clk), .rst_i(rst), .valid_i(c_valid), .ready_o(c_ready_o),
        .data_i(c_data), .mode_i(c_mode), .valid_o(c_valid_o), .ready_i(c_ready_i),
        .data_o(c_data_o), .mode_o(c_mode_o), .count_o(c_count), .xfer_cnt_o(c_xfer)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  mode;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end else begin
            $display("ok   %s: %08h", name, act);
        end
    endtask

    // Monitor: every output transfer of the default instance is checked in order.
    always @(negedge clk) begin
        if (!rst && a_valid_o && a_ready_i) begin
            if (sb.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL pop_unexpected: got %08h expected none at %0t", a_data_o, $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("pop_data", a_data_o, e.data);
                chk("pop_mode", {30'd0, a_mode_o}, {30'd0, e.mode});
            end
        end
    end

    task automatic push_a(input logic [15:0] d, input logic [1:0] m, input logic [31:0] e);
        int waitc;
        waitc = 0;
        while (!a_ready_o && waitc < 20) begin
            @(posedge clk); #1;
            waitc++;
        end
        if (!a_ready_o) begin
            chk("push_timeout_ready", {31'd0, a_ready_o}, 32'd1);
        end else begin
            a_valid = 1'b1;
            a_data  = d;
            a_mode  = m;
            sb.push_back('{data: e, mode: m});
            @(posedge clk); #1;
            a_valid = 1'b0;
        end
    endtask

    task automatic push_c(input logic [11:0] d, input logic [1:0] m, input logic [19:0] e,
                          input string name);
        c_valid = 1'b1;
        c_data  = d;
        c_mode  = m;
        @(posedge clk); #1;
        c_valid = 1'b0;
        @(negedge clk);
        chk(name, {12'd0, c_data_o}, {12'd0, e});
        @(posedge clk); #1;
        c_ready_i = 1'b1;
        @(posedge clk); #1;
        c_ready_i = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        a_valid = 0; a_data = '0; a_mode = '0; a_ready_i = 0;
        b_valid = 0; b_data = '0; b_mode = '0; b_ready_i = 0;
        c_valid = 0; c_data = '0; c_mode = '0; c_ready_i = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", {30'd0, a_count}, 32'd0);
        chk("rst_valid", {31'd0, a_valid_o}, 32'd0);
        chk("rst_ready", {31'd0, a_ready_o}, 32'd1);
        chk("rst_data", a_data_o, 32'd0);
        chk("rst_xfer", {16'd0, a_xfer}, 32'd0);
        rst = 1'b0;

        // Extension modes with free-flowing output
        @(posedge clk); #1;
        a_ready_i = 1'b1;
        push_a(16'h8001, 2'b00, 32'hFFFF8001);
        push_a(16'h8001, 2'b01, 32'h00008001);
        push_a(16'h8001, 2'b10, 32'h80010000);
        push_a(16'hFFFE, 2'b11, 32'hFFFFFFF8);
        push_a(16'h4000, 2'b11, 32'h00010000);
        push_a(16'h7FFF, 2'b00, 32'h00007FFF);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("modes_xfer", {16'd0, a_xfer}, 32'd6);
        chk("modes_count", {30'd0, a_count}, 32'd0);

        // Backpressure: fill, ignored third push, then drain in order
        @(posedge clk); #1;
        a_ready_i = 1'b0;
        push_a(16'h0001, 2'b00, 32'h00000001);
        push_a(16'h0002, 2'b00, 32'h00000002);
        @(negedge clk);
        chk("full_count", {30'd0, a_count}, 32'd2);
        chk("full_ready", {31'd0, a_ready_o}, 32'd0);
        @(posedge clk); #1;
        a_valid = 1'b1; a_data = 16'h0003; a_mode = 2'b00;
        @(posedge clk); #1;
        a_valid = 1'b0;
        @(negedge clk);
        chk("ignored_count", {30'd0, a_count}, 32'd2);
        chk("stall_head", a_data_o, 32'h00000001);
        @(posedge clk); #1;
        a_ready_i = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("drain_count", {30'd0, a_count}, 32'd0);
        chk("drain_xfer", {16'd0, a_xfer}, 32'd8);

        // Simultaneous push and pop at occupancy 1
        @(posedge clk); #1;
        a_ready_i = 1'b0;
        push_a(16'h0005, 2'b00, 32'h00000005);
        a_ready_i = 1'b1;
        push_a(16'h0006, 2'b00, 32'h00000006);
        @(negedge clk);
        chk("pushpop_count", {30'd0, a_count}, 32'd1);
        chk("pushpop_head", a_data_o, 32'h00000006);
        @(posedge clk); #1;
        @(negedge clk);
        chk("pushpop_xfer", {16'd0, a_xfer}, 32'd10);

        // Asynchronous reset while full
        a_ready_i = 1'b0;
        @(posedge clk); #1;
        push_a(16'h000A, 2'b01, 32'h0000000A);
        push_a(16'h000B, 2'b01, 32'h0000000B);
        #1;
        chk("prerst_count", {30'd0, a_count}, 32'd2);
        rst = 1'b1;
        #1;
        chk("arst_count", {30'd0, a_count}, 32'd0);
        chk("arst_valid", {31'd0, a_valid_o}, 32'd0);
        chk("arst_ready", {31'd0, a_ready_o}, 32'd1);
        chk("arst_xfer", {16'd0, a_xfer}, 32'd0);
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("postrst_valid", {31'd0, a_valid_o}, 32'd0);

        // Transfer-counter wrap with a 4-bit counter
        @(posedge clk); #1;
        b_ready_i = 1'b1;
        b_valid   = 1'b1;
        b_data    = 16'h1234;
        repeat (17) @(posedge clk);
        #1;
        b_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("wrap_xfer", {28'd0, b_xfer}, 32'd1);
        chk("wrap_count", {30'd0, b_count}, 32'd0);

        // 12 -> 20 bit instance
        @(posedge clk); #1;
        push_c(12'h800, 2'b00, 20'hFF800, "w20_sign");
        push_c(12'h800, 2'b10, 20'h80000, "w20_upper");
        push_c(12'h800, 2'b01, 20'h00800, "w20_zero");
        push_c(12'h800, 2'b11, 20'hFE000, "w20_branch");
        @(negedge clk);
        chk("w20_xfer", {16'd0, c_xfer}, 32'd4);

        vectors++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: got %0d entries expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
